// File: rtl/datapath_result_collector_pkg.sv
// Shared sizing and arithmetic helpers for consumers of the datapathA pipeline.
// Combinational only; no timing or backpressure of its own.
package datapath_result_collector_pkg;

  // Register stages between in_valid and outR in datapathA.
  localparam int DP_LATENCY = 3;

  // outR = ((x*a)+b)*c: product, one guard bit for the add, then a second product.
  function automatic int dp_out_width(input int wlx, input int wlc);
    return wlx + 2 * wlc + 1;
  endfunction

  // Round half toward +inf, arithmetic shift right, then clamp to a wlo-bit signed range.
  // Working in 64 bits keeps the rounding add overflow-free for any realistic outR width.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] v,
                                                   input int shift,
                                                   input int wlo);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (v + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (wlo - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (wlo - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/datapath_result_collector_sync_fifo.sv
// Synchronous FIFO with registered storage; head visible on rdata, 1-edge push-to-visible.
// Push while full succeeds only with a same-edge pop; pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so the output is defined out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/datapath_result_collector.sv
// Collects datapathA results: valid tracking, round/saturate, FIFO, credit-based in_ready.
// in_valid to out_valid is 4 edges; in_ready drops once queued plus in-flight results fill the FIFO.
module datapath_result_collector
  import datapath_result_collector_pkg::*;
#(
  parameter int WLx   = 8,
  parameter int WLc   = 8,
  parameter int WLo   = 16,
  parameter int SHIFT = 4,
  parameter int DEPTH = 8
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [dp_out_width(WLx, WLc)-1:0] outR,
  output logic signed [WLo-1:0]                  out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [$clog2(DEPTH):0]                 count,
  output logic                                   overflow,
  output logic [1:0]                             pending
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DP_LATENCY-1:0] vld;
  logic signed [63:0]    outr_ext;
  logic [WLo-1:0]        res_word;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [CW:0]           credit_used;

  // vld[i] marks that outR will carry a real result DP_LATENCY-1-i cycles from now.
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld <= '0;
    end else begin
      vld <= {vld[DP_LATENCY-2:0], in_valid};
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DP_LATENCY; i++) begin
      pending = pending + 2'(vld[i]);
    end
  end

  assign outr_ext = 64'(outR);
  assign res_word = WLo'(round_sat(outr_ext, SHIFT, WLo));

  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (WLo),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (vld[DP_LATENCY-1]),
    .pop   (pop),
    .wdata (res_word),
    .rdata (out_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full FIFO that pops on the same edge still takes the new result, so only this case drops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow <= 1'b0;
    end else if (vld[DP_LATENCY-1] && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Same-cycle pops are not credited back, keeping the check conservative.
  assign credit_used = {1'b0, count} + (CW + 1)'(pending);
  assign in_ready    = credit_used < (CW + 1)'(DEPTH);

endmodule

// File: tb/tb_datapath_result_collector.sv
// Directed bench for datapath_result_collector with a queue-based reference model.
module tb_datapath_result_collector;

  localparam int DEPTH = 8;
  localparam int MAXV  = 32767;
  localparam int MINV  = -32768;

  logic               CLK = 1'b0;
  logic               RST;
  logic               in_valid;
  logic               in_ready;
  logic signed [24:0] outR;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         count;
  logic               overflow;
  logic [1:0]         pending;

  logic signed [7:0]  x, a, b, c;
  logic signed [24:0] r1, r2, r3;

  int vectors = 0;
  int errs    = 0;

  datapath_result_collector dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outR      (outR),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .pending   (pending)
  );

  always #5 CLK = ~CLK;

  // Stand-in for datapathA: result of the operands sampled at edge n is on outR during cycle n+3.
  always @(posedge CLK) begin
    r1 <= 25'((int'(x) * int'(a) + int'(b)) * int'(c));
    r2 <= r1;
    r3 <= r2;
  end
  assign outR = r3;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Floor-division form of round-half-up followed by clamping.
  function automatic int model_out(input int xi, input int ai, input int bi, input int ci);
    longint v, t, r;
    v = ((longint'(xi) * ai) + bi) * ci;
    t = v + 8;
    r = t / 16;
    if ((t % 16 != 0) && (t < 0)) r = r - 1;
    if (r > MAXV) r = MAXV;
    if (r < MINV) r = MINV;
    return int'(r);
  endfunction

  // Reference model: stored results, in-flight results with their write edge, sticky overflow.
  int  q[$];
  int  due_q[$];
  int  val_q[$];
  bit  m_ovf = 1'b0;
  bit  started = 1'b0;
  int  ecnt = 0;

  initial begin
    forever begin
      @(posedge CLK);
      ecnt++;
      started = 1'b1;
      if (RST) begin
        q.delete();
        due_q.delete();
        val_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        while (due_q.size() != 0 && due_q[0] == ecnt) begin
          void'(due_q.pop_front());
          if (q.size() < DEPTH) q.push_back(val_q.pop_front());
          else begin
            void'(val_q.pop_front());
            m_ovf = 1'b1;
          end
        end
        if (in_valid) begin
          due_q.push_back(ecnt + 3);
          val_q.push_back(model_out(int'(x), int'(a), int'(b), int'(c)));
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("count", count, q.size());
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) chk("out_data", out_data, q[0]);
      chk("overflow", overflow, m_ovf);
      chk("pending", pending, due_q.size());
      chk("in_ready", in_ready, (q.size() + due_q.size()) < DEPTH);
    end
  end

  task automatic drive(input bit iv, input int xi, input int ai, input int bi, input int ci);
    in_valid = iv;
    x = 8'(xi);
    a = 8'(ai);
    b = 8'(bi);
    c = 8'(ci);
  endtask

  // One transaction with out_ready high: checks the 4-edge latency and a literal result.
  task automatic single(input string nm, input int xi, input int ai, input int bi, input int ci,
                        input int lit);
    int n;
    bit seen;
    @(negedge CLK);
    drive(1'b1, xi, ai, bi, ci);
    @(negedge CLK);
    drive(1'b0, 99, 99, 99, 99);
    n = 1;
    seen = 1'b0;
    while (!seen && n < 20) begin
      if (out_valid === 1'b1) seen = 1'b1;
      else begin
        @(negedge CLK);
        n++;
      end
    end
    chk({nm, "_latency"}, n, 4);
    chk({nm, "_value"}, out_data, lit);
    repeat (2) @(negedge CLK);
    chk({nm, "_drained"}, count, 0);
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, "_count"}, count, 0);
    chk({nm, "_out_valid"}, out_valid, 0);
    chk({nm, "_overflow"}, overflow, 0);
    chk({nm, "_pending"}, pending, 0);
    chk({nm, "_in_ready"}, in_ready, 1);
    chk({nm, "_out_data"}, out_data, 0);
  endtask

  initial begin
    RST = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RST = 1'b0;

    // Basic, rounding boundaries and saturation.
    out_ready = 1'b1;
    single("basic", 10, 3, 5, 2, 4);
    single("round_up", 1, 1, 7, 1, 1);
    single("round_down", 1, 1, 6, 1, 0);
    single("round_neg", 1, 1, -9, 1, 0);
    single("sat_pos", 127, 127, 127, 127, MAXV);
    single("sat_neg", -128, 127, -128, 127, MINV);

    // Backpressure with in_ready obeyed: exactly DEPTH results, no overflow.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      drive(in_ready, i + 1, 1, 0, 16);
    end
    @(negedge CLK);
    drive(1'b0, 99, 99, 99, 99);
    repeat (4) @(negedge CLK);
    chk("bp_count", count, DEPTH);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_overflow", overflow, 0);
    chk("bp_head", out_data, 1);
    out_ready = 1'b1;
    repeat (10) @(negedge CLK);
    chk("bp_drained", count, 0);

    // Forced overflow: 10 results into 8 slots.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      drive(1'b1, i + 1, 1, 0, 16);
    end
    @(negedge CLK);
    drive(1'b0, 99, 99, 99, 99);
    repeat (5) @(negedge CLK);
    chk("ovf_count", count, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", out_data, 1);
    out_ready = 1'b1;
    repeat (10) @(negedge CLK);
    chk("ovf_drained", count, 0);
    chk("ovf_sticky", overflow, 1);

    // Reset mid-flight with queued entries and overflow set.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drive(1'b1, 20 + i, 1, 0, 16);
    end
    @(negedge CLK);
    drive(1'b0, 99, 99, 99, 99);
    repeat (4) @(negedge CLK);
    chk("mid_pre_count", count, 3);
    drive(1'b1, 50, 1, 0, 16);
    @(negedge CLK);
    drive(1'b0, 99, 99, 99, 99);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_reset_values("mid_reset");
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    chk("mid_no_write", count, 0);
    chk("mid_no_valid", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/datapath_result_collector.md
Name: datapath_result_collector

Overview:
Downstream consumer of the datapathA pipeline, which computes outR = ((x*a)+b)*c with 3 register stages and no stall.
- Tracks a valid bit alongside the datapath's fixed latency.
- Rounds and saturates the wide signed outR to an output word.
- Buffers results in a small FIFO with a ready/valid output interface.
- Drives a credit-based in_ready so upstream never overruns the FIFO.

Parameters:
WLx, 8, datapath x width
WLc, 8, datapath coefficient width
WLo, 16, output word width (signed)
SHIFT, 4, right-shift applied before saturation (>=1)
DEPTH, 8, FIFO entries (power of 2, >=4)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous active-high reset
in_valid  in  1  high in the same cycle x/a/b/c are presented to datapathA
in_ready  out  1  upstream may assert in_valid only when high
outR  in  WLx+2*WLc+1  signed datapathA output (WLI = 25 at defaults)
out_data  out  WLo  signed rounded/saturated result, FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts out_data when out_valid&&out_ready
count  out  $clog2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: a result arrived while FIFO full
pending  out  2  valid results in flight in the latency tracker (0..3)

Behaviour:
- Reset (RST high at an edge):
  - count=0, out_valid=0, overflow=0, pending=0, in_ready=1, out_data=0.
  - Valid tracker cleared: in-flight datapath results are discarded, including a reset mid-operation.
  - The FIFO head value is don't-care but driven as 0.
- Latency tracker: 3-stage shift register vld[0..2].
  - vld[0] samples in_valid at edge n, aligned with regMul.
  - vld[2] is high during cycle n+3, exactly when outR holds that sample's result.
- Arithmetic, combinational on outR when vld[2]=1:
  - r = (outR + 2^(SHIFT-1)) >>> SHIFT, computed in WLI+1 bits: round half toward +inf, arithmetic shift.
  - If r > 2^(WLo-1)-1, out = 2^(WLo-1)-1.
  - Else if r < -2^(WLo-1), out = -2^(WLo-1).
  - Else out = r truncated to WLo bits.
- FIFO write at edge n+3 when vld[2]=1; out_valid rises in cycle n+4. Total latency from in_valid to out_valid is 4 edges.
- FIFO pop on out_valid&&out_ready at an edge. out_data always shows the head entry (registered storage, no combinational bypass).
- Simultaneous push and pop:
  - When not empty: count unchanged, both happen.
  - When empty: push only. An empty FIFO never pops, so no bypass.
  - When full: the pop frees the slot and the push succeeds; overflow is not set.
- Push while full with no pop: the result is dropped, overflow is set to 1 and held until RST, count stays DEPTH.
- in_ready = (count + pending) < DEPTH.
  - pending = vld[0]+vld[1]+vld[2].
  - A same-cycle pop is deliberately ignored (conservative).
  - With in_ready obeyed, overflow never sets.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.
- out_valid = (count != 0).

Decomposition:
- Shared package:
  - Function for the datapath output width, WLx+2*WLc+1.
  - Constant for the datapath latency, 3, used by the tracker depth.
  - Round/saturate function, reusable by other datapath variants.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; ports CLK, RST, push, pop, wdata, rdata, count, full, empty).
- Tracker, round/saturate and credit logic stay in the top module.

Test Plan:
- Basic: x=10, a=3, b=5, c=2 (outR=70), out_ready=1 -> out_data=4 ((70+8)>>>4), out_valid exactly 4 edges after in_valid, count returns to 0.
- Rounding boundary: x=1, a=1, b=7, c=1 (outR=8) -> out_data=1; b=6 (outR=7) -> out_data=0; x=1, a=1, b=-9, c=1 (outR=-8) -> out_data=0.
- Saturation:
  - x=127, a=127, b=127, c=127 (outR=2064512) -> out_data=32767.
  - x=-128, a=127, b=-128, c=127 (outR=-2080768) -> out_data=-32768.
- Backpressure: out_ready=0, drive in_valid whenever in_ready -> in_ready falls when count+pending reaches 8, exactly 8 results stored, overflow stays 0; then out_ready=1 -> 8 results drain in order, 1 per cycle.
- Forced overflow: ignore in_ready, 10 back-to-back in_valid with out_ready=0 -> count=8, overflow=1, first 8 results retained in order.
- Reset mid-flight: RST asserted 2 cycles after in_valid -> no write occurs; all outputs at reset values the cycle after; overflow cleared.
